// File: rtl/apim_pkg.sv
// Shared widths, opcodes, FSM states and command bookkeeping for the CIM macro sequencer.
package apim_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;
  localparam int IN_W   = 4;
  localparam int ADC_W  = 6;
  localparam int N_IN   = 4;
  localparam int N_OUT  = 8;
  localparam int LEN_W  = ADDR_W + 1;
  localparam int ACT_W  = N_IN * IN_W;
  localparam int RES_W  = N_OUT * ADC_W;

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(1 << ADDR_W);

  localparam logic OP_LOAD    = 1'b0;
  localparam logic OP_COMPUTE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ISSUE,
    ST_WAIT,
    ST_OUT
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
  } run_t;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    return (len > LEN_MAX) ? LEN_MAX : len;
  endfunction

endpackage

// File: rtl/apim_res_slot.sv
// One-entry result holding register: captures on load, 1 cycle to res_valid;
// data and address stay frozen while res_ready is low.
module apim_res_slot
  import apim_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [RES_W-1:0]  load_data,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              res_ready,
  output logic              res_valid,
  output logic [RES_W-1:0]  res_data,
  output logic [ADDR_W-1:0] res_addr
);

  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_addr  <= '0;
    end else if (load) begin
      res_valid <= 1'b1;
      res_data  <= load_data;
      res_addr  <= load_addr;
    end else if (res_valid && res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/apim_ctrl.sv
// LOAD/COMPUTE sequencer owning all Basic_GeMM_CIM pins; 1 byte/cycle loads, 4 cycles/vector
// at MACRO_LAT=1; w/act streams stall while busy elsewhere, results held until res_ready.
module apim_ctrl
  import apim_pkg::*;
#(
  parameter int MACRO_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [DATA_W-1:0] w_data,
  input  logic              act_valid,
  output logic              act_ready,
  input  logic [ACT_W-1:0]  act_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [RES_W-1:0]  res_data,
  output logic [ADDR_W-1:0] res_addr,
  output logic              busy,
  output logic              done,
  output logic              cs,
  output logic              web,
  output logic              cimeb,
  output logic [ADDR_W-1:0] a,
  output logic [DATA_W-1:0] d,
  output logic [IN_W-1:0]   cim_in0,
  output logic [IN_W-1:0]   cim_in1,
  output logic [IN_W-1:0]   cim_in2,
  output logic [IN_W-1:0]   cim_in3,
  input  logic [ADC_W-1:0]  cim_out0,
  input  logic [ADC_W-1:0]  cim_out1,
  input  logic [ADC_W-1:0]  cim_out2,
  input  logic [ADC_W-1:0]  cim_out3,
  input  logic [ADC_W-1:0]  cim_out4,
  input  logic [ADC_W-1:0]  cim_out5,
  input  logic [ADC_W-1:0]  cim_out6,
  input  logic [ADC_W-1:0]  cim_out7
);

  localparam int LAT_W = (MACRO_LAT < 2) ? 1 : $clog2(MACRO_LAT + 1);

  state_t            state_q, state_d;
  run_t              run_q, run_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic              zero_pend_q, zero_pend_d;
  logic              web_d, cimeb_d, done_d, res_load;
  logic [ADDR_W-1:0] a_d;
  logic [DATA_W-1:0] d_d;
  logic [ACT_W-1:0]  cin_q, cin_d;
  logic [LEN_W-1:0]  len_clamped;

  // cs doubles as "out of reset" so cmd_ready stays low while rst is being applied
  assign cmd_ready   = cs && (state_q == ST_IDLE);
  assign w_ready     = (state_q == ST_LOAD) && (run_q.len != '0);
  assign act_ready   = (state_q == ST_ISSUE);
  assign busy        = (state_q != ST_IDLE);
  assign len_clamped = clamp_len(cmd_len);
  assign {cim_in3, cim_in2, cim_in1, cim_in0} = cin_q;

  always_comb begin
    state_d     = state_q;
    run_d       = run_q;
    lat_d       = lat_q;
    zero_pend_d = 1'b0;
    web_d       = 1'b1;
    cimeb_d     = 1'b1;
    a_d         = a;
    d_d         = d;
    cin_d       = cin_q;
    done_d      = zero_pend_q;
    res_load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          run_d.addr = cmd_addr;
          run_d.len  = len_clamped;
          if (len_clamped == '0) begin
            zero_pend_d = 1'b1;
          end else begin
            state_d = (cmd_op == OP_LOAD) ? ST_LOAD : ST_ISSUE;
          end
        end
      end
      ST_LOAD: begin
        // the final strobe is on the macro pins during this len==0 cycle
        if (run_q.len == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (w_valid) begin
          web_d      = 1'b0;
          a_d        = run_q.addr;
          d_d        = w_data;
          run_d.addr = run_q.addr + ADDR_W'(1);
          run_d.len  = run_q.len - LEN_W'(1);
        end
      end
      ST_ISSUE: begin
        if (act_valid) begin
          cimeb_d = 1'b0;
          a_d     = run_q.addr;
          cin_d   = act_data;
          lat_d   = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (lat_q == LAT_W'(MACRO_LAT)) begin
          res_load = 1'b1;
          state_d  = ST_OUT;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      ST_OUT: begin
        if (res_valid && res_ready) begin
          run_d.addr = run_q.addr + ADDR_W'(1);
          run_d.len  = run_q.len - LEN_W'(1);
          if (run_q.len == LEN_W'(1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      run_q       <= '0;
      lat_q       <= '0;
      zero_pend_q <= 1'b0;
      cs          <= 1'b0;
      web         <= 1'b1;
      cimeb       <= 1'b1;
      a           <= '0;
      d           <= '0;
      cin_q       <= '0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      lat_q       <= lat_d;
      zero_pend_q <= zero_pend_d;
      cs          <= 1'b1;
      web         <= web_d;
      cimeb       <= cimeb_d;
      a           <= a_d;
      d           <= d_d;
      cin_q       <= cin_d;
      done        <= done_d;
    end
  end

  apim_res_slot u_res_slot (
    .clk       (clk),
    .rst       (rst),
    .load      (res_load),
    .load_data ({cim_out7, cim_out6, cim_out5, cim_out4,
                 cim_out3, cim_out2, cim_out1, cim_out0}),
    .load_addr (run_q.addr),
    .res_ready (res_ready),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_addr  (res_addr)
  );

endmodule

// File: tb/tb_apim_ctrl.sv
// Directed bench for apim_ctrl with a behavioural one-cycle-latency CIM macro.
module tb_apim_ctrl;
  import apim_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0, cmd_op = 1'b0, cmd_ready;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [LEN_W-1:0]  cmd_len = '0;
  logic              w_valid = 1'b0, w_ready;
  logic [DATA_W-1:0] w_data = '0;
  logic              act_valid = 1'b0, act_ready;
  logic [ACT_W-1:0]  act_data = '0;
  logic              res_valid, res_ready = 1'b0;
  logic [RES_W-1:0]  res_data;
  logic [ADDR_W-1:0] res_addr, a;
  logic              busy, done, cs, web, cimeb;
  logic [DATA_W-1:0] d;
  logic [IN_W-1:0]   cim_in0, cim_in1, cim_in2, cim_in3;
  logic [ADC_W-1:0]  cim_o [N_OUT];
  logic [ACT_W-1:0]  cin_all;

  int checks = 0, failures = 0, cyc = 0, tmo = 0;
  int done_cnt = 0, done_cyc = -1, both_low = 0;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    int                c;
  } ev_t;
  ev_t wlog[$];
  ev_t clog[$];
  logic [DATA_W-1:0] mem  [1024];
  logic [DATA_W-1:0] wexp [1024];

  always #5 clk = ~clk;

  apim_ctrl #(.MACRO_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .act_valid(act_valid), .act_ready(act_ready), .act_data(act_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_addr(res_addr),
    .busy(busy), .done(done), .cs(cs), .web(web), .cimeb(cimeb), .a(a), .d(d),
    .cim_in0(cim_in0), .cim_in1(cim_in1), .cim_in2(cim_in2), .cim_in3(cim_in3),
    .cim_out0(cim_o[0]), .cim_out1(cim_o[1]), .cim_out2(cim_o[2]), .cim_out3(cim_o[3]),
    .cim_out4(cim_o[4]), .cim_out5(cim_o[5]), .cim_out6(cim_o[6]), .cim_out7(cim_o[7])
  );

  assign cin_all = {cim_in3, cim_in2, cim_in1, cim_in0};

  // Behavioural macro: out_j = bits [13:8] of sum_k in_k * w[{k, a[7:5], j, a[1:0]}]
  function automatic logic [ADC_W-1:0] macro_dot(input int j, input logic [ADDR_W-1:0] ad,
                                                 input logic [ACT_W-1:0] act);
    int s;
    s = 0;
    for (int k = 0; k < N_IN; k++)
      s += int'(act[4*k +: 4]) * int'(mem[{2'(k), ad[7:5], 3'(j), ad[1:0]}]);
    return ADC_W'(s >> 8);
  endfunction

  always @(posedge clk) begin
    if (cs === 1'b1 && web === 1'b0) mem[a] <= d;
    if (cs === 1'b1 && cimeb === 1'b0)
      for (int j = 0; j < N_OUT; j++) cim_o[j] <= macro_dot(j, a, cin_all);
  end

  always @(posedge clk) begin
    ev_t ev;
    #1;
    cyc = cyc + 1;
    ev.a = a; ev.d = d; ev.c = cyc;
    if (web === 1'b0) wlog.push_back(ev);
    if (cimeb === 1'b0) clog.push_back(ev);
    if (web === 1'b0 && cimeb === 1'b0) both_low = both_low + 1;
    if (done === 1'b1) begin done_cnt = done_cnt + 1; done_cyc = cyc; end
  end

  function automatic logic [RES_W-1:0] exp_res(input logic [ADDR_W-1:0] ad, input logic [ACT_W-1:0] act);
    logic [RES_W-1:0] r;
    int s;
    r = '0;
    for (int j = 0; j < N_OUT; j++) begin
      s = 0;
      for (int k = 0; k < N_IN; k++)
        s += int'(act[4*k +: 4]) * int'(wexp[{2'(k), ad[7:5], 3'(j), ad[1:0]}]);
      r[ADC_W*j +: ADC_W] = ADC_W'(s >> 8);
    end
    return r;
  endfunction

  task automatic send_cmd(input logic op, input logic [ADDR_W-1:0] ad, input logic [LEN_W-1:0] ln,
                          output int t_hs);
    int n = 0;
    cmd_op = op; cmd_addr = ad; cmd_len = ln; cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) tmo++;
    t_hs = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic stream_w(input int nb, input logic [ADDR_W-1:0] ad);
    int idx = 0, n = 0;
    logic [DATA_W-1:0] b;
    w_valid = 1'b1;
    while (idx < nb && n < 3000) begin
      b = DATA_W'($urandom);
      w_data = b;
      if (w_ready === 1'b1) begin wexp[ad + ADDR_W'(idx)] = b; idx++; end
      @(negedge clk); n++;
    end
    w_valid = 1'b0;
    if (idx < nb) tmo++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if ({cs, web, cimeb} !== 3'b011) begin failures++;
      $display("FAIL reset_ctrl_pins got=%b want=011", {cs, web, cimeb}); end
    checks++; if ({a, d, cin_all} !== '0) begin failures++;
      $display("FAIL reset_addr_data got=%h want=0", {a, d, cin_all}); end
    checks++; if ({cmd_ready, w_ready, act_ready, res_valid, busy, done} !== 6'b0) begin failures++;
      $display("FAIL reset_handshake got=%b want=000000", {cmd_ready, w_ready, act_ready, res_valid, busy, done}); end
    checks++; if ({res_data, res_addr} !== '0) begin failures++;
      $display("FAIL reset_result got=%h want=0", {res_data, res_addr}); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if ({cs, cmd_ready, busy} !== 3'b110) begin failures++;
      $display("FAIL post_reset_cs_ready got=%b want=110", {cs, cmd_ready, busy}); end
  endtask

  task automatic test_load_full();
    int t, w0, d0, err = 0, merr = 0, first_c = -1, last_c = -1;
    w0 = wlog.size(); d0 = done_cnt;
    send_cmd(OP_LOAD, 10'd0, 11'd1024, t);
    stream_w(1024, 10'd0);
    repeat (3) @(negedge clk);
    if (wlog.size() > w0) begin first_c = wlog[w0].c; last_c = wlog[wlog.size()-1].c; end
    checks++; if (wlog.size() - w0 != 1024) begin failures++;
      $display("FAIL load_full_count got=%0d want=1024", wlog.size() - w0); end
    for (int i = 0; i < 1024 && w0 + i < wlog.size(); i++)
      if (wlog[w0+i].a !== ADDR_W'(i) || wlog[w0+i].d !== wexp[i]) err++;
    checks++; if (err != 0) begin failures++; $display("FAIL load_full_addr_data bad=%0d want=0", err); end
    checks++; if (first_c != t + 2) begin failures++;
      $display("FAIL load_first_strobe cyc=%0d want=%0d", first_c, t + 2); end
    checks++; if (last_c - first_c != 1023) begin failures++;
      $display("FAIL load_back_to_back span=%0d want=1023", last_c - first_c); end
    checks++; if (done_cnt - d0 != 1) begin failures++;
      $display("FAIL load_full_done_count got=%0d want=1", done_cnt - d0); end
    checks++; if (done_cyc != last_c + 1) begin failures++;
      $display("FAIL load_full_done_cyc got=%0d want=%0d", done_cyc, last_c + 1); end
    for (int i = 0; i < 1024; i++) if (mem[i] !== wexp[i]) merr++;
    checks++; if (merr != 0) begin failures++; $display("FAIL load_full_macro_mem bad=%0d want=0", merr); end
  endtask

  task automatic test_load_wrap();
    int t, w0, d0, err = 0, last_c = -1;
    logic [ADDR_W-1:0] exp_a [4];
    exp_a[0] = 10'd1022; exp_a[1] = 10'd1023; exp_a[2] = 10'd0; exp_a[3] = 10'd1;
    w0 = wlog.size(); d0 = done_cnt;
    send_cmd(OP_LOAD, 10'd1022, 11'd4, t);
    stream_w(4, 10'd1022);
    repeat (3) @(negedge clk);
    if (wlog.size() > w0) last_c = wlog[wlog.size()-1].c;
    checks++; if (wlog.size() - w0 != 4) begin failures++;
      $display("FAIL wrap_count got=%0d want=4", wlog.size() - w0); end
    for (int i = 0; i < 4 && w0 + i < wlog.size(); i++)
      if (wlog[w0+i].a !== exp_a[i] || wlog[w0+i].d !== wexp[exp_a[i]]) err++;
    checks++; if (err != 0) begin failures++; $display("FAIL wrap_addr_data bad=%0d want=0", err); end
    checks++; if (done_cnt - d0 != 1 || done_cyc != last_c + 1) begin failures++;
      $display("FAIL wrap_done cnt=%0d cyc=%0d want cnt=1 cyc=%0d", done_cnt - d0, done_cyc, last_c + 1); end
  endtask

  task automatic test_len_clamp();
    int t, w0, d0;
    w0 = wlog.size(); d0 = done_cnt;
    send_cmd(OP_LOAD, 10'd5, 11'd1500, t);
    stream_w(1024, 10'd5);
    w_valid = 1'b1;
    repeat (4) @(negedge clk);
    w_valid = 1'b0;
    checks++; if (wlog.size() - w0 != 1024) begin failures++;
      $display("FAIL clamp_count got=%0d want=1024", wlog.size() - w0); end
    checks++; if (wlog.size() <= w0 || wlog[wlog.size()-1].a !== 10'd4) begin failures++;
      $display("FAIL clamp_last_addr got=%0d want=4", (wlog.size() > w0) ? int'(wlog[wlog.size()-1].a) : -1); end
    checks++; if (done_cnt - d0 != 1) begin failures++;
      $display("FAIL clamp_done got=%0d want=1", done_cnt - d0); end
  endtask

  task automatic test_compute();
    logic [ACT_W-1:0]  vec [3];
    logic [RES_W-1:0]  got_d [3];
    logic [ADDR_W-1:0] got_a [3];
    int ai = 0, ri = 0, n = 0, c0, d0, t, rv_first = -1;
    vec[0] = 16'hF3A1; vec[1] = 16'h0000; vec[2] = 16'hFFFF;
    c0 = clog.size(); d0 = done_cnt; res_ready = 1'b1;
    send_cmd(OP_COMPUTE, 10'h020, 11'd3, t);
    while (ri < 3 && n < 100) begin
      act_valid = (ai < 3);
      if (ai < 3) act_data = vec[ai];
      if (act_valid && act_ready === 1'b1) ai++;
      if (res_valid === 1'b1) begin
        if (rv_first < 0) rv_first = cyc;
        got_d[ri] = res_data; got_a[ri] = res_addr; ri++;
      end
      @(negedge clk); n++;
    end
    act_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (ri != 3) begin failures++; $display("FAIL compute_result_count got=%0d want=3", ri); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (got_a[i] !== 10'h020 + ADDR_W'(i)) begin failures++;
        $display("FAIL compute_res_addr[%0d] got=%h want=%h", i, got_a[i], 10'h020 + ADDR_W'(i)); end
      checks++; if (got_d[i] !== exp_res(10'h020 + ADDR_W'(i), vec[i])) begin failures++;
        $display("FAIL compute_res_data[%0d] got=%h want=%h", i, got_d[i], exp_res(10'h020 + ADDR_W'(i), vec[i])); end
    end
    checks++; if (clog.size() - c0 != 3) begin failures++;
      $display("FAIL compute_strobes got=%0d want=3", clog.size() - c0); end
    checks++; if (clog.size() < c0 + 2 || clog[c0+1].c - clog[c0].c != 4) begin failures++;
      $display("FAIL compute_vector_period want=4 cycles"); end
    checks++; if (clog.size() <= c0 || rv_first != clog[c0].c + 2) begin failures++;
      $display("FAIL compute_latency res_valid_cyc=%0d want strobe+2", rv_first); end
    checks++; if (done_cnt - d0 != 1) begin failures++;
      $display("FAIL compute_done got=%0d want=1", done_cnt - d0); end
  endtask

  task automatic test_backpressure();
    logic [ACT_W-1:0]  vec [2];
    logic [RES_W-1:0]  snap_d, got_d1;
    logic [ADDR_W-1:0] snap_a, got_a1;
    int ai = 0, n = 0, t, d0, cs0, hold_err = 0, rdy_err = 0, got1 = 0;
    vec[0] = 16'h1234; vec[1] = 16'h8421;
    d0 = done_cnt; res_ready = 1'b0;
    send_cmd(OP_COMPUTE, 10'h040, 11'd2, t);
    while (res_valid !== 1'b1 && n < 50) begin
      act_valid = 1'b1; act_data = vec[ai];
      if (act_ready === 1'b1 && ai == 0) ai = 1;
      @(negedge clk); n++;
    end
    act_valid = 1'b1; act_data = vec[1];
    snap_d = res_data; snap_a = res_addr; cs0 = clog.size();
    repeat (10) begin
      @(negedge clk);
      if (res_valid !== 1'b1 || res_data !== snap_d || res_addr !== snap_a) hold_err++;
      if (act_ready !== 1'b0 || cmd_ready !== 1'b0 || busy !== 1'b1) rdy_err++;
    end
    checks++; if (snap_a !== 10'h040) begin failures++; $display("FAIL bp_res_addr got=%h want=040", snap_a); end
    checks++; if (snap_d !== exp_res(10'h040, vec[0])) begin failures++;
      $display("FAIL bp_res_data got=%h want=%h", snap_d, exp_res(10'h040, vec[0])); end
    checks++; if (hold_err != 0) begin failures++; $display("FAIL bp_hold_stable bad=%0d want=0", hold_err); end
    checks++; if (rdy_err != 0) begin failures++; $display("FAIL bp_ready_busy bad=%0d want=0", rdy_err); end
    checks++; if (clog.size() != cs0) begin failures++;
      $display("FAIL bp_no_strobe got=%0d want=0", clog.size() - cs0); end
    res_ready = 1'b1; n = 0;
    @(negedge clk);
    while (got1 == 0 && n < 50) begin
      if (act_ready === 1'b1) act_valid = 1'b1;
      if (res_valid === 1'b1) begin got_d1 = res_data; got_a1 = res_addr; got1 = 1; end
      @(negedge clk); n++;
      if (cimeb === 1'b0) act_valid = 1'b0;
    end
    act_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (got1 != 1 || got_a1 !== 10'h041 || got_d1 !== exp_res(10'h041, vec[1])) begin failures++;
      $display("FAIL bp_resume got_addr=%h got_data=%h want_addr=041 want_data=%h", got_a1, got_d1, exp_res(10'h041, vec[1])); end
    checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL bp_done got=%0d want=1", done_cnt - d0); end
  endtask

  task automatic test_len0();
    int t, w0, c0, d0, busy_seen = 0;
    w0 = wlog.size(); c0 = clog.size(); d0 = done_cnt;
    send_cmd(OP_LOAD, 10'h100, 11'd0, t);
    repeat (3) begin if (busy !== 1'b0) busy_seen++; @(negedge clk); end
    checks++; if (done_cnt - d0 != 1 || done_cyc != t + 2) begin failures++;
      $display("FAIL len0_done cnt=%0d cyc=%0d want cnt=1 cyc=%0d", done_cnt - d0, done_cyc, t + 2); end
    checks++; if (wlog.size() != w0 || clog.size() != c0 || busy_seen != 0) begin failures++;
      $display("FAIL len0_no_strobe web=%0d cimeb=%0d busy=%0d want all 0", wlog.size() - w0, clog.size() - c0, busy_seen); end
  endtask

  task automatic test_rst_wait();
    int t, n = 0, w0, c0, d0, rv_seen = 0, got = 0;
    logic [RES_W-1:0] gd;
    logic [ADDR_W-1:0] ga;
    res_ready = 1'b1;
    send_cmd(OP_COMPUTE, 10'h060, 11'd2, t);
    act_valid = 1'b1; act_data = 16'hC3E7;
    while (cimeb !== 1'b0 && n < 50) begin @(negedge clk); n++; end
    act_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    checks++; if ({cs, web, cimeb, a, d, cin_all} !== {3'b011, 34'h0}) begin failures++;
      $display("FAIL rstwait_macro_pins got=%h want=%h", {cs, web, cimeb, a, d, cin_all}, {3'b011, 34'h0}); end
    checks++; if ({cmd_ready, w_ready, act_ready, res_valid, busy, done, res_data, res_addr} !== '0) begin failures++;
      $display("FAIL rstwait_outputs got=%h want=0", {cmd_ready, w_ready, act_ready, res_valid, busy, done, res_data, res_addr}); end
    rst = 1'b0;
    w0 = wlog.size(); c0 = clog.size(); d0 = done_cnt;
    repeat (6) begin @(negedge clk); if (res_valid !== 1'b0) rv_seen++; end
    checks++; if (done_cnt != d0 || rv_seen != 0 || wlog.size() != w0 || clog.size() != c0) begin failures++;
      $display("FAIL rstwait_quiet done=%0d res_valid=%0d strobes=%0d want all 0", done_cnt - d0, rv_seen, clog.size() - c0 + wlog.size() - w0); end
    send_cmd(OP_COMPUTE, 10'h060, 11'd1, t);
    act_valid = 1'b1; act_data = 16'h5A5A; n = 0;
    while (got == 0 && n < 50) begin
      if (res_valid === 1'b1) begin gd = res_data; ga = res_addr; got = 1; end
      @(negedge clk); n++;
      if (cimeb === 1'b0) act_valid = 1'b0;
    end
    act_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (got != 1 || ga !== 10'h060 || gd !== exp_res(10'h060, 16'h5A5A)) begin failures++;
      $display("FAIL rstwait_rerun addr=%h data=%h want_addr=060 want_data=%h", ga, gd, exp_res(10'h060, 16'h5A5A)); end
    checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL rstwait_rerun_done got=%0d want=1", done_cnt - d0); end
  endtask

  task automatic test_invariants();
    checks++; if (both_low != 0) begin failures++; $display("FAIL web_cimeb_both_low got=%0d want=0", both_low); end
    checks++; if (tmo != 0) begin failures++; $display("FAIL handshake_timeouts got=%0d want=0", tmo); end
  endtask

  initial begin
    test_reset();
    test_load_full();
    test_load_wrap();
    test_len_clamp();
    test_compute();
    test_backpressure();
    test_len0();
    test_rst_wait();
    test_invariants();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
